// File: rtl/ghr_spec_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ghr_spec_ctrl
//  Description : Speculative global-history controller with per-branch
//                checkpoint queue for a dual-issue fetch front end.
//  Revision    : 1.0  initial release
// ============================================================================
module ghr_spec_ctrl #(
    parameter int HIST_W = 6,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fetch_br0,
    input  logic              fetch_pred0,
    input  logic              fetch_br1,
    input  logic              fetch_pred1,
    output logic              fetch_ready,
    input  logic              res_valid,
    input  logic              res_taken,
    input  logic              res_mispredict,
    input  logic              flush,
    output logic [HIST_W-1:0] ghr_spec,
    output logic [HIST_W-1:0] ghr_commit,
    output logic [PTR_W:0]    count,
    output logic              underflow_err
);

    localparam logic [PTR_W:0] c_READY_MAX = (PTR_W+1)'(DEPTH - 2);

    logic [HIST_W-1:0] r_spec;
    logic [HIST_W-1:0] r_commit;
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [PTR_W:0]    r_count;
    logic              r_uf;
    logic [HIST_W-1:0] r_ckpt [DEPTH];

    logic              w_res_legal;
    logic              w_mispredict;
    logic              w_fetch_acc;
    logic [PTR_W:0]    w_n;
    logic [PTR_W:0]    w_n_acc;
    logic [PTR_W:0]    w_dec;
    logic [PTR_W-1:0]  w_head_inc;
    logic [PTR_W-1:0]  w_head_next;
    logic [PTR_W-1:0]  w_tail_p1;
    logic [PTR_W-1:0]  w_tail_fetch;
    logic [HIST_W-1:0] w_commit_next;
    logic [HIST_W-1:0] w_spec_fetch;
    logic [HIST_W-1:0] w_spec_repair;

    assign fetch_ready   = (r_count <= c_READY_MAX);
    assign ghr_spec      = r_spec;
    assign ghr_commit    = r_commit;
    assign count         = r_count;
    assign underflow_err = r_uf;

    // A resolve is only legal when something is outstanding.
    assign w_res_legal   = res_valid && (r_count != '0);
    assign w_mispredict  = w_res_legal && res_mispredict;
    assign w_fetch_acc   = fetch_ready && !flush && !w_mispredict;

    assign w_n           = {{PTR_W{1'b0}}, fetch_br0} + {{PTR_W{1'b0}}, fetch_br1};
    assign w_n_acc       = w_fetch_acc ? w_n : '0;
    assign w_dec         = {{PTR_W{1'b0}}, w_res_legal};

    assign w_head_inc    = r_head + 1'b1;
    assign w_head_next   = w_res_legal ? w_head_inc : r_head;
    assign w_tail_p1     = r_tail + 1'b1;
    assign w_tail_fetch  = r_tail + w_n[PTR_W-1:0];

    assign w_commit_next = w_res_legal ? {r_commit[HIST_W-2:0], res_taken} : r_commit;
    assign w_spec_repair = {r_ckpt[r_head][HIST_W-2:0], res_taken};

    always_comb begin
        w_spec_fetch = r_spec;
        unique case ({fetch_br0, fetch_br1})
            2'b11:   w_spec_fetch = {r_spec[HIST_W-3:0], fetch_pred0, fetch_pred1};
            2'b10:   w_spec_fetch = {r_spec[HIST_W-2:0], fetch_pred0};
            2'b01:   w_spec_fetch = {r_spec[HIST_W-2:0], fetch_pred1};
            default: w_spec_fetch = r_spec;
        endcase
    end

    // Queue storage carries no reset; entries are only read once written.
    always_ff @(posedge clock) begin
        if (!reset && w_fetch_acc) begin
            if (fetch_br0 || fetch_br1)
                r_ckpt[r_tail] <= r_spec;
            if (fetch_br0 && fetch_br1)
                r_ckpt[w_tail_p1] <= {r_spec[HIST_W-2:0], fetch_pred0};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_spec   <= '0;
            r_commit <= '0;
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_uf     <= 1'b0;
        end else begin
            if (res_valid && (r_count == '0))
                r_uf <= 1'b1;
            r_commit <= w_commit_next;
            if (flush) begin
                r_spec  <= w_commit_next;
                r_head  <= w_head_next;
                r_tail  <= w_head_next;
                r_count <= '0;
            end else if (w_mispredict) begin
                r_spec  <= w_spec_repair;
                r_head  <= w_head_inc;
                r_tail  <= w_head_inc;
                r_count <= '0;
            end else begin
                r_head  <= w_head_next;
                r_count <= r_count + w_n_acc - w_dec;
                if (w_fetch_acc) begin
                    r_spec <= w_spec_fetch;
                    r_tail <= w_tail_fetch;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ghr_spec_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ghr_spec_ctrl
//  Description : Scoreboard bench for ghr_spec_ctrl with a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ghr_spec_ctrl;

    localparam int HW = 6;
    localparam int DP = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic       fetch_br0, fetch_pred0, fetch_br1, fetch_pred1;
    logic       fetch_ready;
    logic       res_valid, res_taken, res_mispredict, flush;
    logic [5:0] ghr_spec, ghr_commit;
    logic [3:0] count;
    logic       underflow_err;

    ghr_spec_ctrl #(.HIST_W(6), .DEPTH(8), .PTR_W(3)) dut (
        .clock(clock), .reset(reset),
        .fetch_br0(fetch_br0), .fetch_pred0(fetch_pred0),
        .fetch_br1(fetch_br1), .fetch_pred1(fetch_pred1),
        .fetch_ready(fetch_ready),
        .res_valid(res_valid), .res_taken(res_taken),
        .res_mispredict(res_mispredict), .flush(flush),
        .ghr_spec(ghr_spec), .ghr_commit(ghr_commit),
        .count(count), .underflow_err(underflow_err)
    );

    always #5 clock = ~clock;

    // {spec, commit, count, ready, underflow}
    logic [17:0] sb[$];
    logic [17:0] exp_v;
    int          n_pass  = 0;
    int          n_total = 0;

    logic [5:0] m_spec, m_commit;
    logic [5:0] m_ckpt [DP];
    int         m_head, m_tail, m_count;
    logic       m_uf;

    function automatic logic [17:0] observed();
        return {ghr_spec, ghr_commit, count, fetch_ready, underflow_err};
    endfunction

    task automatic model_step();
        bit         legal, misp, acc;
        logic [5:0] nc;
        logic [1:0] br, pr;
        legal = res_valid && (m_count > 0);
        misp  = legal && res_mispredict;
        acc   = (m_count <= DP - 2) && !flush && !misp;
        nc    = legal ? {m_commit[4:0], res_taken} : m_commit;
        br    = {fetch_br1, fetch_br0};
        pr    = {fetch_pred1, fetch_pred0};
        if (reset) begin
            m_spec = '0; m_commit = '0; m_head = 0; m_tail = 0; m_count = 0; m_uf = 1'b0;
        end else begin
            if (res_valid && m_count == 0) m_uf = 1'b1;
            if (flush) begin
                m_head  = (m_head + (legal ? 1 : 0)) % DP;
                m_tail  = m_head;
                m_count = 0;
                m_spec  = nc;
            end else if (misp) begin
                m_spec  = {m_ckpt[m_head][4:0], res_taken};
                m_head  = (m_head + 1) % DP;
                m_tail  = m_head;
                m_count = 0;
            end else begin
                if (acc) begin
                    for (int s = 0; s < 2; s++) begin
                        if (br[s]) begin
                            m_ckpt[m_tail] = m_spec;
                            m_spec  = {m_spec[4:0], pr[s]};
                            m_tail  = (m_tail + 1) % DP;
                            m_count = m_count + 1;
                        end
                    end
                end
                if (legal) begin
                    m_head  = (m_head + 1) % DP;
                    m_count = m_count - 1;
                end
            end
            m_commit = nc;
        end
    endtask

    task automatic drive(input logic rst, input logic b0, input logic p0,
                         input logic b1, input logic p1, input logic rv,
                         input logic rt, input logic rm, input logic fl);
        reset = rst; fetch_br0 = b0; fetch_pred0 = p0; fetch_br1 = b1; fetch_pred1 = p1;
        res_valid = rv; res_taken = rt; res_mispredict = rm; flush = fl;
        model_step();
        sb.push_back({m_spec, m_commit, 4'(m_count), (m_count <= DP - 2) ? 1'b1 : 1'b0, m_uf});
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        void'(sb.pop_front());
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        void'(sb.pop_front());
    endtask

    task automatic test_reset();
        drive(1, 1, 1, 1, 1, 1, 1, 0, 0);
        exp_v = sb.pop_front();
        n_total++;
        if (observed() !== 18'b000000_000000_0000_1_0)
            $display("FAIL reset_state: got %h expected %h", observed(), 18'b000000_000000_0000_1_0);
        else n_pass++;
        n_total++;
        if (observed() !== exp_v) $display("FAIL reset_sb: got %h expected %h", observed(), exp_v);
        else n_pass++;
    endtask

    task automatic test_dual_fetch();
        drive(0, 1, 1, 1, 0, 0, 0, 0, 0);
        exp_v = sb.pop_front();
        n_total++;
        if ({ghr_spec, count, fetch_ready} !== {6'b000010, 4'd2, 1'b1})
            $display("FAIL dual_fetch: got spec=%b cnt=%0d rdy=%b expected spec=000010 cnt=2 rdy=1",
                     ghr_spec, count, fetch_ready);
        else n_pass++;
        n_total++;
        if (observed() !== exp_v) $display("FAIL dual_fetch_sb: got %h expected %h", observed(), exp_v);
        else n_pass++;
    endtask

    task automatic test_fill();
        logic [5:0] held;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, i[0], 1, 1, 0, 0, 0, 0);
            exp_v = sb.pop_front();
            n_total++;
            if (observed() !== exp_v) $display("FAIL fill_sb: got %h expected %h", observed(), exp_v);
            else n_pass++;
        end
        n_total++;
        if ({count, fetch_ready} !== {4'd8, 1'b0})
            $display("FAIL fill_full: got cnt=%0d rdy=%b expected cnt=8 rdy=0", count, fetch_ready);
        else n_pass++;
        held = ghr_spec;
        drive(0, 1, 0, 1, 0, 0, 0, 0, 0);
        exp_v = sb.pop_front();
        n_total++;
        if ({ghr_spec, count} !== {held, 4'd8})
            $display("FAIL fill_ignored: got spec=%b cnt=%0d expected spec=%b cnt=8", ghr_spec, count, held);
        else n_pass++;
        // Drain to 7 (still not ready) then 6 (ready again)
        drive(0, 0, 0, 0, 0, 1, 1, 0, 0);
        exp_v = sb.pop_front();
        n_total++;
        if ({count, fetch_ready} !== {4'd7, 1'b0})
            $display("FAIL fill_seven: got cnt=%0d rdy=%b expected cnt=7 rdy=0", count, fetch_ready);
        else n_pass++;
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
        exp_v = sb.pop_front();
        n_total++;
        if ({count, fetch_ready} !== {4'd6, 1'b1})
            $display("FAIL fill_six: got cnt=%0d rdy=%b expected cnt=6 rdy=1", count, fetch_ready);
        else n_pass++;
    endtask

    task automatic test_mispredict();
        logic [5:0] pbits;
        do_reset();
        drive(0, 1, 0, 1, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 1, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 1, 1, 0, 0, 0, 0);
        pbits = 6'b001011;
        for (int i = 5; i >= 0; i--) drive(0, 0, 0, 0, 0, 1, pbits[i], 0, 0);
        drive(0, 1, 1, 1, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0, 0, 0, 0);
        while (sb.size() > 0) begin
            exp_v = sb.pop_front();
            if (sb.size() == 0) begin
                n_total++;
                if (observed() !== exp_v) $display("FAIL misp_setup: got %h expected %h", observed(), exp_v);
                else n_pass++;
            end
        end
        n_total++;
        if ({ghr_spec, ghr_commit, count} !== {6'b011101, 6'b001011, 4'd3})
            $display("FAIL misp_pre: got spec=%b commit=%b cnt=%0d expected 011101 001011 3",
                     ghr_spec, ghr_commit, count);
        else n_pass++;
        drive(0, 1, 1, 1, 1, 1, 0, 1, 0);
        exp_v = sb.pop_front();
        n_total++;
        if ({ghr_spec, ghr_commit, count} !== {6'b010110, 6'b010110, 4'd0})
            $display("FAIL misp_repair: got spec=%b commit=%b cnt=%0d expected 010110 010110 0",
                     ghr_spec, ghr_commit, count);
        else n_pass++;
        n_total++;
        if (observed() !== exp_v) $display("FAIL misp_sb: got %h expected %h", observed(), exp_v);
        else n_pass++;
    endtask

    task automatic test_resolve_and_fetch();
        drive(0, 1, 1, 1, 1, 0, 0, 0, 0);
        exp_v = sb.pop_front();
        drive(0, 1, 1, 0, 0, 1, 1, 0, 0);
        exp_v = sb.pop_front();
        n_total++;
        if ({ghr_spec, ghr_commit, count} !== {6'b110111, 6'b101101, 4'd2})
            $display("FAIL res_fetch: got spec=%b commit=%b cnt=%0d expected 110111 101101 2",
                     ghr_spec, ghr_commit, count);
        else n_pass++;
        n_total++;
        if (observed() !== exp_v) $display("FAIL res_fetch_sb: got %h expected %h", observed(), exp_v);
        else n_pass++;
    endtask

    task automatic test_flush();
        do_reset();
        drive(0, 1, 1, 1, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 1, 1, 0, 0);
        drive(0, 1, 1, 1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 1, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0, 0, 0, 0);
        while (sb.size() > 0) exp_v = sb.pop_front();
        n_total++;
        if ({ghr_commit, count} !== {6'b000111, 4'd5})
            $display("FAIL flush_pre: got commit=%b cnt=%0d expected 000111 5", ghr_commit, count);
        else n_pass++;
        drive(0, 1, 0, 1, 0, 1, 1, 0, 1);
        exp_v = sb.pop_front();
        n_total++;
        if ({ghr_spec, ghr_commit, count} !== {6'b001111, 6'b001111, 4'd0})
            $display("FAIL flush_state: got spec=%b commit=%b cnt=%0d expected 001111 001111 0",
                     ghr_spec, ghr_commit, count);
        else n_pass++;
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        exp_v = sb.pop_front();
        n_total++;
        if (observed() !== exp_v) $display("FAIL flush_after_sb: got %h expected %h", observed(), exp_v);
        else n_pass++;
    endtask

    task automatic test_underflow();
        do_reset();
        drive(0, 0, 0, 0, 0, 1, 1, 1, 0);
        exp_v = sb.pop_front();
        n_total++;
        if ({underflow_err, ghr_commit, count} !== {1'b1, 6'b000000, 4'd0})
            $display("FAIL underflow_set: got uf=%b commit=%b cnt=%0d expected 1 000000 0",
                     underflow_err, ghr_commit, count);
        else n_pass++;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        exp_v = sb.pop_front();
        n_total++;
        if (underflow_err !== 1'b1) $display("FAIL underflow_held: got %b expected 1", underflow_err);
        else n_pass++;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        exp_v = sb.pop_front();
        n_total++;
        if (underflow_err !== 1'b0) $display("FAIL underflow_clear: got %b expected 0", underflow_err);
        else n_pass++;
    endtask

    task automatic test_random();
        logic rst, fl;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            fl  = ($urandom_range(0, 29) == 0);
            drive(rst, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 2) == 0), 1'($urandom), ($urandom_range(0, 5) == 0), fl);
            exp_v = sb.pop_front();
            n_total++;
            if (observed() !== exp_v)
                $display("FAIL random_sb[%0d]: got %h expected %h", i, observed(), exp_v);
            else n_pass++;
        end
    endtask

    initial begin
        m_spec = '0; m_commit = '0; m_head = 0; m_tail = 0; m_count = 0; m_uf = 1'b0;
        for (int i = 0; i < DP; i++) m_ckpt[i] = '0;
        test_reset();
        test_dual_fetch();
        test_fill();
        test_mispredict();
        test_resolve_and_fetch();
        test_flush();
        test_underflow();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
